// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the runtime-loadable LUT neuron.
//   state_e    : load/serve state machine encoding
//   nwords()   : number of config words needed to fill one table
//   TABLE_BITS : table size in bits for the default neuron geometry
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        COMMIT  = 2'd2,
        READY   = 2'd3
    } state_e;

    function automatic int nwords(input int in_bits, input int out_bits, input int load_w);
        return ((1 << in_bits) * out_bits) / load_w;
    endfunction

    localparam int TABLE_BITS = (1 << 8) * 1;

endpackage

// File: rtl/lut_table_ram.sv
// Distributed table storage for one LUT neuron.
//   clk, rst : clock; rst only clears the read register, never the contents
//   wr_en    : write one config word
//   wr_addr  : config word index
//   wr_data  : config word
//   rd_en    : perform a lookup this cycle
//   rd_addr  : table entry index
//   rd_data  : registered table entry, holds when rd_en is low
module lut_table_ram #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int LOAD_W   = 32,
    parameter int WA       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [WA-1:0]       wr_addr,
    input  logic [LOAD_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [IN_BITS-1:0]  rd_addr,
    output logic [OUT_BITS-1:0] rd_data
);
    localparam int TBITS = (1 << IN_BITS) * OUT_BITS;

    (* ram_style = "distributed" *) logic [TBITS-1:0] r_mem;
    logic [OUT_BITS-1:0] r_rd;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[int'(wr_addr) * LOAD_W +: LOAD_W] <= wr_data;
        end
    end

    // Read samples the pre-write contents when a write lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd <= '0;
        end else if (rd_en) begin
            r_rd <= r_mem[int'(rd_addr) * OUT_BITS +: OUT_BITS];
        end
    end

    assign rd_data = r_rd;

endmodule

// File: rtl/lut_neuron_cfg_writer.sv
// Runtime-programmable LUT neuron: loads a truth table from a serialized
// valid/ready word stream, then serves registered lookups M0 -> M1.
//   clk, rst   : clock, synchronous active-high reset
//   cfg_valid  : config word valid
//   cfg_ready  : writer accepts a word (registered)
//   cfg_data   : config word, word k carries table bits [k*LOAD_W +: LOAD_W]
//   cfg_last   : final word of a table
//   cfg_done   : table loaded, lookups enabled
//   cfg_err    : sticky framing error, cleared by a successful commit
//   in_valid   : lookup request
//   M0         : lookup index
//   out_valid  : M1 valid, one cycle after the request
//   M1         : table[M0]
module lut_neuron_cfg_writer
    import lut_cfg_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int LOAD_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [LOAD_W-1:0]   cfg_data,
    input  logic                cfg_last,
    output logic                cfg_done,
    output logic                cfg_err,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  M0,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] M1
);
    localparam int TBITS  = (1 << IN_BITS) * OUT_BITS;
    localparam int NWORDS = nwords(IN_BITS, OUT_BITS, LOAD_W);
    localparam int CNT_W  = $clog2(NWORDS) + 1;
    localparam int WA     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    generate
        if ((TBITS % LOAD_W) != 0 || NWORDS < 1) begin : g_bad_geometry
            $error("table bits must be a non-zero multiple of LOAD_W");
        end
    endgenerate

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cfg_ready;
    logic             r_cfg_done;
    logic             r_cfg_err;
    logic             r_out_valid;

    logic             w_xfer;
    logic [WA-1:0]    w_wr_addr;
    logic             w_rd_en;

    assign w_xfer    = cfg_valid && r_cfg_ready;
    // Outside LOADING every accepted word is the first word of a table.
    assign w_wr_addr = (r_state == LOADING) ? r_cnt[WA-1:0] : '0;
    assign w_rd_en   = in_valid && r_cfg_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_cnt       <= '0;
            r_cfg_ready <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_ready <= 1'b1;
            case (r_state)
                EMPTY, READY: begin
                    if (w_xfer) begin
                        r_cfg_done <= 1'b0;
                        if (NWORDS == 1) begin
                            if (cfg_last) begin
                                r_state     <= COMMIT;
                                r_cfg_ready <= 1'b0;
                            end else begin
                                r_cfg_err <= 1'b1;
                                r_state   <= EMPTY;
                            end
                            r_cnt <= '0;
                        end else if (cfg_last) begin
                            r_cfg_err <= 1'b1;
                            r_state   <= EMPTY;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt   <= CNT_W'(1);
                            r_state <= LOADING;
                        end
                    end
                end
                LOADING: begin
                    if (w_xfer) begin
                        if (r_cnt == LAST_IDX) begin
                            if (cfg_last) begin
                                r_state     <= COMMIT;
                                r_cfg_ready <= 1'b0;
                            end else begin
                                r_cfg_err <= 1'b1;
                                r_state   <= EMPTY;
                            end
                            r_cnt <= '0;
                        end else if (cfg_last) begin
                            r_cfg_err <= 1'b1;
                            r_state   <= EMPTY;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    r_state    <= READY;
                    r_cfg_done <= 1'b1;
                    r_cfg_err  <= 1'b0;
                    r_cnt      <= '0;
                end
                default: begin
                    r_state <= EMPTY;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_rd_en;
        end
    end

    lut_table_ram #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS),
        .LOAD_W  (LOAD_W),
        .WA      (WA)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (w_xfer),
        .wr_addr(w_wr_addr),
        .wr_data(cfg_data),
        .rd_en  (w_rd_en),
        .rd_addr(M0),
        .rd_data(M1)
    );

    assign cfg_ready = r_cfg_ready;
    assign cfg_done  = r_cfg_done;
    assign cfg_err   = r_cfg_err;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_lut_neuron_cfg_writer.sv
module tb_lut_neuron_cfg_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;
    logic        cfg_last;
    logic        cfg_done;
    logic        cfg_err;
    logic        in_valid;
    logic [7:0]  M0;
    logic        out_valid;
    logic [0:0]  M1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]  wbuf [8];
    logic [255:0] model;

    typedef struct {
        logic [7:0] m0;
        logic       exp;
    } vec_t;
    vec_t vecs [6];

    lut_neuron_cfg_writer #(.IN_BITS(8), .OUT_BITS(1), .LOAD_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_data (cfg_data),
        .cfg_last (cfg_last),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .in_valid (in_valid),
        .M0       (M0),
        .out_valid(out_valid),
        .M1       (M1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One config transfer; waits (bounded) for cfg_ready first.
    task automatic send(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = last;
        while (!cfg_ready && n < 20) begin
            tick();
            n++;
        end
        if (!cfg_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: cfg_ready got 0 expected 1");
        end
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic load_words(input int n, input int last_idx);
        for (int k = 0; k < n; k++) begin
            send(wbuf[k], (k == last_idx));
        end
    endtask

    task automatic set_model();
        for (int k = 0; k < 8; k++) model[k*32 +: 32] = wbuf[k];
    endtask

    initial begin
        vecs[0] = '{m0: 8'h04, exp: 1'b0};
        vecs[1] = '{m0: 8'h05, exp: 1'b1};
        vecs[2] = '{m0: 8'hFF, exp: 1'b1};
        vecs[3] = '{m0: 8'h00, exp: 1'b1};
        vecs[4] = '{m0: 8'h03, exp: 1'b1};
        vecs[5] = '{m0: 8'h14, exp: 1'b1};

        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
        in_valid = 1'b0; M0 = '0;
        tick(); tick();
        chk("rst_ready", 32'(cfg_ready), 0);
        chk("rst_done", 32'(cfg_done), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_M1", 32'(M1), 0);
        rst = 1'b0;
        tick();

        // Load 1: all ones except entry 4.
        for (int k = 0; k < 8; k++) wbuf[k] = 32'hFFFF_FFFF;
        wbuf[0] = 32'hFFFF_FFEF;
        load_words(8, 7);
        chk("commit_ready_low", 32'(cfg_ready), 0);
        chk("commit_done_low", 32'(cfg_done), 0);
        tick();
        chk("ready_after_commit", 32'(cfg_ready), 1);
        chk("done_after_commit", 32'(cfg_done), 1);
        chk("err_after_commit", 32'(cfg_err), 0);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            M0 = vecs[i].m0;
            tick();
            chk($sformatf("lookup1_ov_%0h", vecs[i].m0), 32'(out_valid), 1);
            chk($sformatf("lookup1_m1_%0h", vecs[i].m0), 32'(M1), 32'(vecs[i].exp));
        end
        in_valid = 1'b0;
        tick();
        chk("idle_out_valid", 32'(out_valid), 0);
        chk("idle_M1_holds", 32'(M1), 1);

        // Early last on word 3.
        load_words(4, 3);
        chk("early_err", 32'(cfg_err), 1);
        chk("early_done", 32'(cfg_done), 0);
        chk("early_ready", 32'(cfg_ready), 1);
        in_valid = 1'b1; M0 = 8'h05;
        tick();
        chk("early_lookup_blocked", 32'(out_valid), 0);
        in_valid = 1'b0;
        load_words(8, 7);
        tick();
        chk("recover_err_clear", 32'(cfg_err), 0);
        chk("recover_done", 32'(cfg_done), 1);

        // Missing last.
        load_words(7, -1);
        chk("missing_err_pre", 32'(cfg_err), 0);
        send(wbuf[7], 1'b0);
        chk("missing_err", 32'(cfg_err), 1);
        chk("missing_done", 32'(cfg_done), 0);

        // Reset mid-load, then alternating pattern.
        load_words(5, -1);
        rst = 1'b1;
        tick();
        chk("midrst_done", 32'(cfg_done), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_err", 32'(cfg_err), 0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) wbuf[k] = 32'hAAAA_AAAA;
        load_words(8, 7);
        tick();
        chk("alt_done", 32'(cfg_done), 1);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            M0 = 8'(8'h10 + i * 8'h13);
            tick();
            chk($sformatf("alt_m1_%0h", 8'(8'h10 + i * 8'h13)), 32'(M1), 32'(M0[0]));
        end
        in_valid = 1'b0;

        // Irregular table, full back-to-back sweep.
        for (int k = 0; k < 8; k++) wbuf[k] = 32'hDEAD_BEEF ^ (32'(k) * 32'h1111_1111);
        set_model();
        load_words(8, 7);
        tick();
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            M0 = 8'(i);
            tick();
            chk($sformatf("sweep_ov_%0d", i), 32'(out_valid), 1);
            chk($sformatf("sweep_m1_%0d", i), 32'(M1), 32'(model[i]));
        end

        // Reload starting on the same cycle as a lookup of 0x04.
        M0 = 8'h04;
        send(32'h0000_0010, 1'b0);
        chk("reload_old_ov", 32'(out_valid), 1);
        chk("reload_old_m1", 32'(M1), 32'(model[4]));
        tick();
        chk("reload_blocked_0", 32'(out_valid), 0);
        for (int k = 1; k < 8; k++) begin
            send(32'h0, (k == 7));
            chk($sformatf("reload_blocked_w%0d", k), 32'(out_valid), 0);
        end
        tick();
        chk("reload_commit_edge_ov", 32'(out_valid), 0);
        chk("reload_done", 32'(cfg_done), 1);
        tick();
        chk("reload_new_ov", 32'(out_valid), 1);
        chk("reload_new_m1", 32'(M1), 1);
        M0 = 8'h05;
        tick();
        chk("reload_new_m1_05", 32'(M1), 0);
        in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lut_neuron_cfg_writer.md
Name: lut_neuron_cfg_writer

Overview:
- Runtime-programmable counterpart to the fixed truth-table neurons.
- Accepts a neuron's truth table as a serialized word stream over a valid/ready config port and writes it into an internal 2^IN_BITS x OUT_BITS distributed table.
- Once loaded, serves registered lookups with the same M0 -> M1 mapping a generated neuron implements.
- Sits between the configuration/DMA path and the layer datapath, so neuron functions can be swapped without resynthesis.

Parameters:
- IN_BITS, 8, neuron input width; table depth = 2^IN_BITS.
- OUT_BITS, 1, neuron output width per entry.
- LOAD_W, 32, config word width; (2^IN_BITS * OUT_BITS) must be a multiple of LOAD_W (elaboration error otherwise).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_valid  in  1  config word valid.
- cfg_ready  out  1  writer can accept a config word.
- cfg_data  in  LOAD_W  config word.
- cfg_last  in  1  marks the final word of a table.
- cfg_done  out  1  table fully loaded; lookups enabled.
- cfg_err  out  1  sticky framing error.
- in_valid  in  1  lookup request.
- M0  in  IN_BITS  lookup index (unsigned; M0[IN_BITS-1] is the MSB).
- out_valid  out  1  M1 valid.
- M1  out  OUT_BITS  table[M0].

Behaviour:
- Sizes: NWORDS = 2^IN_BITS*OUT_BITS/LOAD_W (defaults: 8). Word k carries table bits [k*LOAD_W +: LOAD_W]. Entry i occupies bits [i*OUT_BITS +: OUT_BITS]. Words arrive in order, k = 0 first.
- Transfer: occurs when cfg_valid && cfg_ready. No combinational path from cfg_valid to cfg_ready.
- State machine, states EMPTY, LOADING, COMMIT, READY:
  - EMPTY: cfg_ready=1, cfg_done=0. A transfer writes word 0, sets word counter to 1, goes to LOADING. Exception: a transfer with cfg_last=1 when NWORDS>1 sets cfg_err and stays in EMPTY.
  - LOADING: cfg_ready=1. Each transfer writes the word at the counter and increments it.
    - cfg_last=1 with counter==NWORDS-1: write the word, go to COMMIT.
    - cfg_last=1 with counter<NWORDS-1 (early last): set cfg_err, go to EMPTY; partial data is discarded logically.
    - cfg_last=0 with counter==NWORDS-1 (missing last): set cfg_err, go to EMPTY.
  - COMMIT: single cycle, cfg_ready=0. Next state READY, cfg_done=1, cfg_err cleared.
  - READY: cfg_ready=1, cfg_done=1. A transfer starts a reload: cfg_done drops to 0 in the next cycle, and the same word handling as EMPTY applies.
- Lookups:
  - When cfg_done=1 and in_valid=1 at edge t: M1 = table[M0] and out_valid=1 at edge t+1. Latency is exactly 1 cycle, full throughput, one lookup per cycle.
  - Any cycle with cfg_done=0 or in_valid=0 gives out_valid=0 next cycle. M1 holds its last value.
  - Simultaneous config transfer and lookup in READY: the lookup completes using pre-write contents; from the next cycle lookups are blocked.
- Reset values: state EMPTY, word counter 0, cfg_done=0, cfg_err=0, out_valid=0, M1=0, cfg_ready=0 while rst is asserted. Table contents are not reset.
  - Reset mid-load: all progress is abandoned; a full reload is required.
- Counter: $clog2(NWORDS)+1 bits; it never wraps because of the framing checks.

Decomposition:
- Package lut_cfg_pkg holds:
  - state enum (EMPTY, LOADING, COMMIT, READY);
  - function nwords(IN_BITS, OUT_BITS, LOAD_W);
  - localparam TABLE_BITS.
- Sub-module lut_table_ram (parameters IN_BITS, OUT_BITS, LOAD_W):
  - distributed RAM with rom_style/ram_style "distributed";
  - write port: word address + LOAD_W data;
  - synchronous read port: entry address -> OUT_BITS.
- The FSM, framing checks and valid pipeline stay in the top module.

Test Plan:
- Load 8 words of 0xFFFFFFFF except word 0 = 0xFFFFFFEF, cfg_last on word 7 -> cfg_ready low for exactly 1 cycle (COMMIT), then cfg_done=1. Lookups then return: M0=0x04 -> M1=0 one cycle later; M0=0x05 -> M1=1; M0=0xFF -> M1=1.
- cfg_last asserted on word 3 -> cfg_err=1, cfg_done=0, state EMPTY. Lookups give out_valid=0. A subsequent correct 8-word load clears cfg_err and sets cfg_done=1.
- 8 words with cfg_last never asserted -> cfg_err=1 after word 7, cfg_done=0.
- Assert rst after 5 words -> cfg_done=0, out_valid=0. A full 8-word reload of alternating 0xAAAAAAAA yields M1 = M0[0] for every M0 (M1=0 for M0=0x10, M1=1 for M0=0x11).
- In READY, stream M0 = 0..255 back to back with in_valid=1 -> 256 consecutive out_valid pulses, each matching the loaded table, each 1 cycle late.
- In READY, start a reload on the same cycle as a lookup of 0x04 -> that lookup returns the old value, and out_valid stays 0 until the new COMMIT.
